// File: rtl/memory_stage.sv
// Y86-64 memory stage: decodes the access from icode, runs one req/ack data-memory
// transaction at a time and hands the result to writeback over a valid/ready handshake.
module memory_stage #(
  parameter int ADDR_W      = 64,
  parameter int MEM_BYTES   = 8192,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [2:0]        in_stat,
  input  logic [63:0]       in_valE,
  input  logic [63:0]       in_valA,
  input  logic [63:0]       in_valP,
  input  logic              in_cnd,
  input  logic [3:0]        in_dstE,
  input  logic [3:0]        in_dstM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [2:0]        out_stat,
  output logic [63:0]       out_valE,
  output logic [63:0]       out_valM,
  output logic              out_cnd,
  output logic [3:0]        out_dstE,
  output logic [3:0]        out_dstM
);

  localparam int          CNT_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);
  localparam logic [2:0]  STAT_AOK  = 3'd1;
  localparam logic [2:0]  STAT_HLT  = 3'd2;
  localparam logic [2:0]  STAT_ADR  = 3'd3;
  localparam logic [2:0]  STAT_INS  = 3'd4;
  localparam logic [3:0]  REG_NONE  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [63:0]         r_mem_wdata;
  logic                r_out_valid;
  logic [3:0]          r_out_icode;
  logic [2:0]          r_out_stat;
  logic [63:0]         r_out_valE;
  logic [63:0]         r_out_valM;
  logic                r_out_cnd;
  logic [3:0]          r_out_dstE;
  logic [3:0]          r_out_dstM;
  logic                r_is_read;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_is_write;
  logic                w_is_read;
  logic [63:0]         w_addr;
  logic [63:0]         w_wdata;
  logic                w_access;
  logic                w_oob;
  logic                w_go_mem;
  logic [2:0]          w_cap_stat;

  // Access decode and capture-time status for the instruction offered by execute.
  always_comb begin
    w_is_write = 1'b0;
    w_is_read  = 1'b0;
    w_addr     = in_valE;
    w_wdata    = in_valA;
    case (in_icode)
      4'd4, 4'd10: w_is_write = 1'b1;
      4'd8: begin
        w_is_write = 1'b1;
        w_wdata    = in_valP;
      end
      4'd5: w_is_read = 1'b1;
      4'd9, 4'd11: begin
        w_is_read = 1'b1;
        w_addr    = in_valA;
      end
      default: begin
        w_is_write = 1'b0;
        w_is_read  = 1'b0;
      end
    endcase
    w_access = w_is_write | w_is_read;
    // Unsigned compare, so addresses that would wrap past 2^64 are rejected too.
    w_oob    = (w_addr > LAST_ADDR);
    if (in_stat != STAT_AOK) begin
      w_cap_stat = in_stat;
    end else if (w_access && w_oob) begin
      w_cap_stat = STAT_ADR;
    end else if (in_icode == 4'd0) begin
      w_cap_stat = STAT_HLT;
    end else if (in_icode > 4'd11) begin
      w_cap_stat = STAT_INS;
    end else begin
      w_cap_stat = STAT_AOK;
    end
    w_go_mem = (in_stat == STAT_AOK) && w_access && !w_oob;
  end

  // Stage control FSM with all handshake, memory and result outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 64'd0;
      r_out_valid <= 1'b0;
      r_out_icode <= 4'd0;
      r_out_stat  <= STAT_AOK;
      r_out_valE  <= 64'd0;
      r_out_valM  <= 64'd0;
      r_out_cnd   <= 1'b0;
      r_out_dstE  <= REG_NONE;
      r_out_dstM  <= REG_NONE;
      r_is_read   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_ready  <= 1'b0;
            r_out_icode <= in_icode;
            r_out_stat  <= w_cap_stat;
            r_out_valE  <= in_valE;
            r_out_valM  <= 64'd0;
            r_out_cnd   <= in_cnd;
            r_out_dstE  <= (in_icode == 4'd2 && !in_cnd) ? REG_NONE : in_dstE;
            r_out_dstM  <= in_dstM;
            r_is_read   <= w_is_read;
            r_cnt       <= '0;
            if (w_go_mem) begin
              r_state     <= ST_MEM;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_write;
              r_mem_addr  <= w_addr[ADDR_W-1:0];
              r_mem_wdata <= w_wdata;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_MEM: begin
          // An ack arriving in the last allowed cycle still counts as success.
          if (mem_ack) begin
            if (r_is_read) begin
              r_out_valM <= mem_rdata;
            end
            r_out_stat  <= STAT_AOK;
            r_state     <= ST_DONE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_out_valid <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_out_stat  <= STAT_ADR;
            r_out_valM  <= 64'd0;
            r_state     <= ST_DONE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign out_valid = r_out_valid;
  assign out_icode = r_out_icode;
  assign out_stat  = r_out_stat;
  assign out_valE  = r_out_valE;
  assign out_valM  = r_out_valM;
  assign out_cnd   = r_out_cnd;
  assign out_dstE  = r_out_dstE;
  assign out_dstM  = r_out_dstM;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized
// transactions compared against a rule-level reference model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode;
  logic [2:0]  in_stat;
  logic [63:0] in_valE, in_valA, in_valP;
  logic        in_cnd;
  logic [3:0]  in_dstE, in_dstM;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        out_valid, out_ready;
  logic [3:0]  out_icode;
  logic [2:0]  out_stat;
  logic [63:0] out_valE, out_valM;
  logic        out_cnd;
  logic [3:0]  out_dstE, out_dstM;

  int tot = 0;
  int bad = 0;

  memory_stage #(.ADDR_W(64), .MEM_BYTES(8192), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode), .in_stat(in_stat),
    .in_valE(in_valE), .in_valA(in_valA), .in_valP(in_valP), .in_cnd(in_cnd),
    .in_dstE(in_dstE), .in_dstM(in_dstM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_stat(out_stat), .out_valE(out_valE), .out_valM(out_valM), .out_cnd(out_cnd),
    .out_dstE(out_dstE), .out_dstM(out_dstM)
  );

  always #5 clk = ~clk;

  // Observations of one transaction
  int          obs_req_cycles, obs_first_valid, obs_valid_cycles;
  logic        obs_we, obs_unstable, obs_ready_bad, obs_cnd;
  logic [63:0] obs_addr, obs_wdata, obs_valE, obs_valM;
  logic [2:0]  obs_stat;
  logic [3:0]  obs_icode, obs_dstE, obs_dstM;

  // Reference-model expectations
  logic        exp_access, exp_we, exp_cnd;
  logic [63:0] exp_addr, exp_wdata, exp_valM, exp_valE;
  logic [2:0]  exp_stat;
  logic [3:0]  exp_icode, exp_dstE, exp_dstM;
  int          exp_req_cycles, exp_first_valid;

  task automatic model_txn(input logic [3:0] icode, input logic [2:0] stat,
                           input logic [63:0] valE, input logic [63:0] valA,
                           input logic [63:0] valP, input logic cnd,
                           input logic [3:0] dstE, input logic [3:0] dstM,
                           input int ack_delay, input logic [63:0] rdata);
    logic is_wr, is_rd, legal;
    is_wr = (icode == 4'd4) || (icode == 4'd8) || (icode == 4'd10);
    is_rd = (icode == 4'd5) || (icode == 4'd9) || (icode == 4'd11);
    exp_addr  = (icode == 4'd9 || icode == 4'd11) ? valA : valE;
    exp_wdata = (icode == 4'd8) ? valP : valA;
    exp_we    = is_wr;
    legal     = ({1'b0, exp_addr} + 65'd8) <= 65'd8192;
    exp_icode = icode; exp_valE = valE; exp_cnd = cnd; exp_dstM = dstM;
    exp_dstE  = (icode == 4'd2 && cnd == 1'b0) ? 4'd15 : dstE;
    exp_valM  = 64'd0;
    exp_access = 1'b0;
    exp_req_cycles = 0;
    if (stat != 3'd1)                 exp_stat = stat;
    else if ((is_wr || is_rd) && !legal) exp_stat = 3'd3;
    else if (!(is_wr || is_rd))       exp_stat = (icode == 4'd0) ? 3'd2 : (icode > 4'd11) ? 3'd4 : 3'd1;
    else begin
      exp_access = 1'b1;
      if (ack_delay >= 1 && ack_delay <= 16) begin
        exp_stat = 3'd1;
        exp_req_cycles = ack_delay;
        if (is_rd) exp_valM = rdata;
      end else begin
        exp_stat = 3'd3;
        exp_req_cycles = 16;
      end
    end
    exp_first_valid = exp_access ? exp_req_cycles + 1 : 1;
  endtask

  // Drives one instruction, plays memory and writeback, records what it saw.
  task automatic drive_txn(input logic [3:0] icode, input logic [2:0] stat,
                           input logic [63:0] valE, input logic [63:0] valA,
                           input logic [63:0] valP, input logic cnd,
                           input logic [3:0] dstE, input logic [3:0] dstM,
                           input int ack_delay, input logic [63:0] rdata,
                           input int ready_delay, input bit spurious);
    int w, cyc;
    bit seen, done;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    tot++;
    if (!in_ready) begin bad++; $display("FAIL wait_in_ready: in_ready=%b required 1", in_ready); end
    in_icode = icode; in_stat = stat; in_valE = valE; in_valA = valA; in_valP = valP;
    in_cnd = cnd; in_dstE = dstE; in_dstM = dstM; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valE = {$urandom, $urandom}; in_valA = {$urandom, $urandom}; in_icode = 4'($urandom);
    obs_req_cycles = 0; obs_first_valid = 0; obs_valid_cycles = 0;
    obs_unstable = 1'b0; obs_ready_bad = 1'b0; obs_we = 1'b0; obs_addr = 64'd0; obs_wdata = 64'd0;
    seen = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 200) begin
      cyc++;
      if (mem_req) begin
        obs_req_cycles++;
        if (in_ready) obs_ready_bad = 1'b1;
        if (obs_req_cycles == 1) begin
          obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
        end else if (mem_addr !== obs_addr || mem_we !== obs_we || mem_wdata !== obs_wdata) begin
          obs_unstable = 1'b1;
        end
      end
      if (out_valid) begin
        if (in_ready) obs_ready_bad = 1'b1;
        if (!seen) begin
          seen = 1'b1; obs_first_valid = cyc;
          obs_stat = out_stat; obs_valM = out_valM; obs_valE = out_valE; obs_icode = out_icode;
          obs_cnd = out_cnd; obs_dstE = out_dstE; obs_dstM = out_dstM;
        end else if (out_stat !== obs_stat || out_valM !== obs_valM || out_valE !== obs_valE ||
                     out_dstE !== obs_dstE || out_dstM !== obs_dstM || out_icode !== obs_icode) begin
          obs_unstable = 1'b1;
        end
        obs_valid_cycles++;
      end else if (seen) begin
        done = 1'b1;
      end
      mem_ack   = mem_req ? (obs_req_cycles == ack_delay) : (spurious ? 1'($urandom_range(0, 1)) : 1'b0);
      mem_rdata = (mem_req && mem_ack) ? rdata : {$urandom, $urandom};
      out_ready = out_valid && (obs_valid_cycles > ready_delay);
      if (!done) begin @(posedge clk); #1; end
    end
    mem_ack = 1'b0; out_ready = 1'b0;
    tot++;
    if (!done) begin bad++; $display("FAIL txn_complete: finished=%b required 1 (icode %0d)", done, icode); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_icode = 4'd0; in_stat = 3'd1; in_valE = 64'd0;
    in_valA = 64'd0; in_valP = 64'd0; in_cnd = 1'b0; in_dstE = 4'd0; in_dstM = 4'd0;
    mem_ack = 1'b0; mem_rdata = 64'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    tot++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tot++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem: req=%b we=%b want 0 0", mem_req, mem_we); end
    tot++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tot++; if (out_stat !== 3'd1 || out_dstE !== 4'd15 || out_dstM !== 4'd15) begin
      bad++; $display("FAIL reset_out_regs: stat=%0d dstE=%0d dstM=%0d want 1 15 15", out_stat, out_dstE, out_dstM); end
    tot++; if (out_valE !== 64'd0 || out_valM !== 64'd0 || out_icode !== 4'd0 || out_cnd !== 1'b0) begin
      bad++; $display("FAIL reset_out_data: valE=%h valM=%h icode=%0d cnd=%b want zeros", out_valE, out_valM, out_icode, out_cnd); end
  endtask

  task automatic test_rmmovq();
    drive_txn(4'd4, 3'd1, 64'h100, 64'hDEADBEEF, 64'd0, 1'b1, 4'd15, 4'd15, 3, 64'd0, 0, 1'b0);
    tot++; if (obs_req_cycles != 3) begin bad++; $display("FAIL rmmovq_req_cycles: got %0d want 3", obs_req_cycles); end
    tot++; if (obs_addr !== 64'h100 || obs_we !== 1'b1 || obs_wdata !== 64'hDEADBEEF) begin
      bad++; $display("FAIL rmmovq_bus: addr=%h we=%b wdata=%h want 100 1 deadbeef", obs_addr, obs_we, obs_wdata); end
    tot++; if (obs_stat !== 3'd1 || obs_first_valid != 4) begin
      bad++; $display("FAIL rmmovq_result: stat=%0d first_valid=%0d want 1 4", obs_stat, obs_first_valid); end
    tot++; if (obs_unstable) begin bad++; $display("FAIL rmmovq_stable: unstable=%b want 0", obs_unstable); end
  endtask

  task automatic test_mrmovq();
    drive_txn(4'd5, 3'd1, 64'h40, 64'd0, 64'd0, 1'b1, 4'd15, 4'd7, 1, 64'h1234, 0, 1'b0);
    tot++; if (obs_valM !== 64'h1234 || obs_dstM !== 4'd7) begin
      bad++; $display("FAIL mrmovq_result: valM=%h dstM=%0d want 1234 7", obs_valM, obs_dstM); end
    tot++; if (obs_first_valid != 2 || obs_we !== 1'b0 || obs_addr !== 64'h40) begin
      bad++; $display("FAIL mrmovq_access: first_valid=%0d we=%b addr=%h want 2 0 40", obs_first_valid, obs_we, obs_addr); end
  endtask

  task automatic test_ret_addr();
    drive_txn(4'd9, 3'd1, 64'h2000, 64'h1FF8, 64'd0, 1'b1, 4'd4, 4'd15, 2, 64'h77, 0, 1'b0);
    tot++; if (obs_addr !== 64'h1FF8 || obs_stat !== 3'd1 || obs_valM !== 64'h77) begin
      bad++; $display("FAIL ret_legal: addr=%h stat=%0d valM=%h want 1ff8 1 77", obs_addr, obs_stat, obs_valM); end
    drive_txn(4'd9, 3'd1, 64'h2000, 64'h1FF9, 64'd0, 1'b1, 4'd4, 4'd15, 1, 64'h77, 0, 1'b0);
    tot++; if (obs_req_cycles != 0 || obs_stat !== 3'd3 || obs_valM !== 64'd0) begin
      bad++; $display("FAIL ret_oob: req_cycles=%0d stat=%0d valM=%h want 0 3 0", obs_req_cycles, obs_stat, obs_valM); end
    drive_txn(4'd5, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1'b1, 4'd15, 4'd2, 1, 64'h5, 0, 1'b0);
    tot++; if (obs_req_cycles != 0 || obs_stat !== 3'd3) begin
      bad++; $display("FAIL wrap_oob: req_cycles=%0d stat=%0d want 0 3", obs_req_cycles, obs_stat); end
  endtask

  task automatic test_timeout();
    drive_txn(4'd11, 3'd1, 64'h0, 64'h80, 64'd0, 1'b1, 4'd4, 4'd3, 0, 64'h99, 0, 1'b0);
    tot++; if (obs_req_cycles != 16) begin bad++; $display("FAIL timeout_req_cycles: got %0d want 16", obs_req_cycles); end
    tot++; if (obs_stat !== 3'd3 || obs_valM !== 64'd0) begin
      bad++; $display("FAIL timeout_result: stat=%0d valM=%h want 3 0", obs_stat, obs_valM); end
    drive_txn(4'd11, 3'd1, 64'h0, 64'h80, 64'd0, 1'b1, 4'd4, 4'd3, 16, 64'h99, 0, 1'b0);
    tot++; if (obs_req_cycles != 16 || obs_stat !== 3'd1 || obs_valM !== 64'h99) begin
      bad++; $display("FAIL ack_last_cycle: req=%0d stat=%0d valM=%h want 16 1 99", obs_req_cycles, obs_stat, obs_valM); end
  endtask

  task automatic test_cmov_backpressure();
    drive_txn(4'd2, 3'd1, 64'h55, 64'h66, 64'd0, 1'b0, 4'd3, 4'd15, 1, 64'd0, 5, 1'b1);
    tot++; if (obs_valid_cycles != 6 || obs_unstable) begin
      bad++; $display("FAIL cmov_hold: valid_cycles=%0d unstable=%b want 6 0", obs_valid_cycles, obs_unstable); end
    tot++; if (obs_ready_bad) begin bad++; $display("FAIL cmov_in_ready: in_ready_high_while_busy=%b want 0", obs_ready_bad); end
    tot++; if (obs_dstE !== 4'd15 || obs_valE !== 64'h55 || obs_first_valid != 1) begin
      bad++; $display("FAIL cmov_result: dstE=%0d valE=%h first_valid=%0d want 15 55 1", obs_dstE, obs_valE, obs_first_valid); end
  endtask

  task automatic test_reset_mid();
    in_icode = 4'd4; in_stat = 3'd1; in_valE = 64'h200; in_valA = 64'h1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    tot++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midrst_pre: mem_req=%b want 1", mem_req); end
    rst_n = 1'b0; #1;
    tot++; if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_async: mem_req=%b out_valid=%b want 0 0", mem_req, out_valid); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    drive_txn(4'd0, 3'd1, 64'd0, 64'd0, 64'd0, 1'b1, 4'd15, 4'd15, 1, 64'd0, 0, 1'b0);
    tot++; if (obs_stat !== 3'd2 || obs_req_cycles != 0) begin
      bad++; $display("FAIL midrst_halt: stat=%0d req=%0d want 2 0", obs_stat, obs_req_cycles); end
  endtask

  task automatic test_random();
    logic [3:0]  icode, dstE, dstM;
    logic [2:0]  stat;
    logic [63:0] a [2];
    logic [63:0] valP, rdata;
    logic        cnd;
    int          ack_delay, ready_delay;
    for (int n = 0; n < 60; n++) begin
      icode = 4'($urandom_range(0, 15));
      stat  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 3))
          0: a[k] = 64'($urandom_range(0, 8184));
          1: a[k] = 64'($urandom_range(8176, 8200));
          2: a[k] = {32'hFFFF_FFFF, $urandom};
          default: a[k] = {$urandom, $urandom};
        endcase
      end
      valP = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      cnd = 1'($urandom); dstE = 4'($urandom); dstM = 4'($urandom);
      ack_delay = $urandom_range(1, 20); ready_delay = $urandom_range(0, 3);
      model_txn(icode, stat, a[0], a[1], valP, cnd, dstE, dstM, ack_delay, rdata);
      drive_txn(icode, stat, a[0], a[1], valP, cnd, dstE, dstM, ack_delay, rdata, ready_delay, 1'b1);
      tot++; if (obs_stat !== exp_stat) begin bad++; $display("FAIL rnd%0d_stat: got %0d want %0d icode %0d", n, obs_stat, exp_stat, icode); end
      tot++; if (obs_valM !== exp_valM) begin bad++; $display("FAIL rnd%0d_valM: got %h want %h", n, obs_valM, exp_valM); end
      tot++; if (obs_req_cycles != exp_req_cycles) begin bad++; $display("FAIL rnd%0d_req: got %0d want %0d", n, obs_req_cycles, exp_req_cycles); end
      tot++; if (obs_first_valid != exp_first_valid) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", n, obs_first_valid, exp_first_valid); end
      tot++; if (obs_valE !== exp_valE || obs_icode !== exp_icode || obs_cnd !== exp_cnd ||
                 obs_dstE !== exp_dstE || obs_dstM !== exp_dstM) begin
        bad++; $display("FAIL rnd%0d_fields: valE=%h icode=%0d cnd=%b dstE=%0d dstM=%0d want %h %0d %b %0d %0d", n,
                        obs_valE, obs_icode, obs_cnd, obs_dstE, obs_dstM, exp_valE, exp_icode, exp_cnd, exp_dstE, exp_dstM); end
      if (exp_access) begin
        tot++; if (obs_addr !== exp_addr || obs_we !== exp_we || (exp_we && obs_wdata !== exp_wdata)) begin
          bad++; $display("FAIL rnd%0d_bus: addr=%h we=%b wdata=%h want %h %b %h", n, obs_addr, obs_we, obs_wdata, exp_addr, exp_we, exp_wdata); end
      end
      tot++; if (obs_unstable || obs_ready_bad || obs_valid_cycles != ready_delay + 1) begin
        bad++; $display("FAIL rnd%0d_handshake: unstable=%b ready_bad=%b valid_cycles=%0d want 0 0 %0d", n,
                        obs_unstable, obs_ready_bad, obs_valid_cycles, ready_delay + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_rmmovq();
    test_mrmovq();
    test_ret_addr();
    test_timeout();
    test_cmov_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Y86-64 memory stage that sits directly downstream of execute and consumes its valE, cnd and forwarded operands. It decodes the access type from icode, runs a req/ack transaction on a single-port data memory, and captures valM. It assigns status (AOK/HLT/ADR/INS) and presents the result to writeback over a valid/ready handshake. Only one instruction is in flight at a time.

Parameters:
ADDR_W, 64, byte-address width driven on mem_addr
MEM_BYTES, 8192, data memory size in bytes; legal access iff addr+8 <= MEM_BYTES
ACK_TIMEOUT, 16, max cycles waiting for mem_ack before the access is declared ADR

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute presents an instruction
in_ready  out  1  stage can accept (high only in IDLE)
in_icode  in  4  instruction code
in_stat  in  3  upstream status (1 AOK, 2 HLT, 3 ADR, 4 INS)
in_valE  in  64  ALU result / address
in_valA  in  64  store data / ret-popq address
in_valP  in  64  return address for call
in_cnd  in  1  condition from execute
in_dstE  in  4  dest register E (15 = none)
in_dstM  in  4  dest register M (15 = none)
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  byte address
mem_wdata  out  64  write data
mem_ack  in  1  memory completes request (rdata valid same cycle)
mem_rdata  in  64  read data
out_valid  out  1  result valid to writeback
out_ready  in  1  writeback accepts
out_icode  out  4  registered icode
out_stat  out  3  final status
out_valE  out  64  registered valE
out_valM  out  64  loaded value (0 if no read)
out_cnd  out  1  registered cnd
out_dstE  out  4  registered dstE (forced 15 when icode=2 and cnd=0)
out_dstM  out  4  registered dstM

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1 after release; mem_req=0, mem_we=0, out_valid=0; all out_* data = 0, out_dstE=out_dstM=15, out_stat=1; timeout counter 0.
- Access decode: write for icode 4 (addr valE, data valA), 8 (addr valE, data valP), 10 (addr valE, data valA); read for 5 (addr valE), 9 and 11 (addr valA); all others no access.
- States: IDLE, MEM, DONE.
- IDLE: in_ready=1. On in_valid, capture all inputs.
  - Capture with in_stat != 1: no access -> DONE, stat passed through.
  - Capture with out-of-range address: no access -> DONE, stat=3.
  - Capture with no access: -> DONE, stat = in_stat, except icode 0 -> 2 and icode > 11 -> 4.
  - Capture with a valid access: -> MEM.
- MEM: mem_req=1, with mem_we/mem_addr/mem_wdata held stable until ack.
  - On mem_ack: latch mem_rdata into valM (reads only), stat=1, -> DONE, mem_req drops next cycle.
  - Counter increments each MEM cycle. Counter reaching ACK_TIMEOUT without ack: stat=3, valM=0, -> DONE.
  - Ack in the timeout cycle wins.
- DONE: out_valid=1 with all out_* stable.
  - On out_ready: -> IDLE, out_valid=0 next cycle.
  - No back-to-back acceptance: in_ready stays low in DONE. Latency is 2 cycles min for non-memory ops, and 2+N cycles for memory ops (N = cycles to ack).
- Range check is unsigned: addr > MEM_BYTES-8 is ADR, including wrap-around near 2^64.
- mem_ack outside MEM is ignored.
- Reset mid-transaction aborts immediately: mem_req drops asynchronously and the instruction is lost.
- After a HLT/ADR/INS result, the stage continues to accept input; halting is handled by the downstream stage.

Test Plan:
- rmmovq: icode=4, valE=0x100, valA=0xDEADBEEF, ack after 3 cycles -> mem_req/we=1 at addr 0x100 with wdata 0xDEADBEEF for 3 cycles; out_stat=1, out_valid 1 cycle later.
- mrmovq: icode=5, valE=0x40, rdata=0x1234 with ack on 1st MEM cycle -> out_valM=0x1234, dstM passed, total latency 3 cycles.
- ret/popq address: icode=9, valA=0x1FF8, valE=0x2000 -> mem_addr=0x1FF8 (legal); valA=0x1FF9 -> no mem_req, out_stat=3.
- Timeout: icode=11, no ack -> mem_req high 16 cycles, out_stat=3, out_valM=0.
- Backpressure/cmov: icode=2, cnd=0, dstE=3, out_ready low 5 cycles -> out_valid held, in_ready=0, out_dstE=15.
- Reset during MEM: rst_n low mid-request -> mem_req=0 immediately, out_valid=0; next icode=0 -> out_stat=2.
